// File: rtl/cla_pkg.sv
// Shared types and sizing helpers for the pipelined carry-lookahead adder.
package cla_pkg;

   localparam int unsigned MAX_GROUP  = 8;
   localparam int unsigned MAX_WIDTH  = 128;
   // Narrowest legal group is 2 bits, so this bounds the group count.
   localparam int unsigned MAX_GROUPS = MAX_WIDTH / 2;

   // Number of lookahead groups; the top group may be narrower than the rest.
   function automatic int unsigned ngroups(input int unsigned width, input int unsigned group);
      return (width + group - 1) / group;
   endfunction

   // Payload held between the p/g stage and the carry/sum stage. Sized for the
   // widest configuration; only the low WIDTH / NG bits carry information.
   typedef struct packed {
      logic [MAX_WIDTH-1:0]  p;
      logic [MAX_WIDTH-1:0]  g;
      logic [MAX_GROUPS-1:0] pm;
      logic [MAX_GROUPS-1:0] gm;
      logic                  c0;
      logic                  a_msb;
      logic                  bx_msb;
   } stage1_t;

endpackage

// File: rtl/clu_nbits.sv
// N-bit carry-lookahead unit: flat sum-of-products carries plus group p/g.
module clu_nbits #(
   parameter int unsigned N = 4
) (
   input  logic [N-1:0] p,
   input  logic [N-1:0] g,
   input  logic         cin,
   output logic [N-1:0] cout,
   output logic         pm,
   output logic         gm
);

   localparam int NI = int'(N);

   // Carry into each bit and group generate, each as an OR of AND terms.
   always_comb begin
      logic term;
      cout = '0;
      gm   = 1'b0;
      term = 1'b0;
      for (int i = 0; i < NI; i++) begin
         term = cin;
         for (int k = 0; k < i; k++) term = term & p[k];
         cout[i] = term;
         for (int j = 0; j < i; j++) begin
            term = g[j];
            for (int k = j + 1; k < i; k++) term = term & p[k];
            cout[i] = cout[i] | term;
         end
      end
      for (int j = 0; j < NI; j++) begin
         term = g[j];
         for (int k = j + 1; k < NI; k++) term = term & p[k];
         gm = gm | term;
      end
   end

   assign pm = &p;

endmodule

// File: rtl/cla_adder_pipe.sv
// Pipelined two-level carry-lookahead adder/subtractor with valid/ready flow control.
module cla_adder_pipe
   import cla_pkg::*;
#(
   parameter int unsigned WIDTH  = 32,
   parameter int unsigned GROUP  = 4,
   parameter int unsigned STAGES = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   input  logic             sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             ovf,
   output logic             zero
);

   localparam int unsigned Grp      = (GROUP > MAX_GROUP) ? MAX_GROUP : GROUP;
   localparam int unsigned NG       = ngroups(WIDTH, Grp);
   localparam int unsigned RW       = WIDTH + 3;
   localparam int unsigned ResStage = (STAGES == 1) ? 0 : 1;

   // ---------------- stage 1: operand prep and bit/group p,g ----------------
   logic [WIDTH-1:0] bx, p1, g1, unused_c1;
   logic [NG-1:0]    pm1, gm1;
   logic             c0;
   stage1_t          s1_in, s1_use;

   assign bx = sub ? ~b : b;
   assign c0 = sub ? ~cin : cin;
   assign p1 = a ^ bx;
   assign g1 = a & bx;

   for (genvar gi = 0; gi < NG; gi++) begin : g_grp1
      localparam int unsigned Base = gi * Grp;
      localparam int unsigned Len  = (Base + Grp > WIDTH) ? WIDTH - Base : Grp;
      clu_nbits #(.N(Len)) u_clu (
         .p    (p1[Base +: Len]),
         .g    (g1[Base +: Len]),
         .cin  (1'b0),
         .cout (unused_c1[Base +: Len]),
         .pm   (pm1[gi]),
         .gm   (gm1[gi])
      );
   end

   // Pack the stage-1 payload; unused upper bits stay zero.
   always_comb begin
      s1_in              = '0;
      s1_in.p[WIDTH-1:0] = p1;
      s1_in.g[WIDTH-1:0] = g1;
      s1_in.pm[NG-1:0]   = pm1;
      s1_in.gm[NG-1:0]   = gm1;
      s1_in.c0           = c0;
      s1_in.a_msb        = a[WIDTH-1];
      s1_in.bx_msb       = bx[WIDTH-1];
   end

   // ---------------- stage 2: group carries, bit carries, sum ----------------
   logic [WIDTH-1:0] p2, g2, c2, sum_c;
   logic [NG-1:0]    pm2, gm2, gc, unused_pm2, unused_gm2;
   logic             tree_pm, tree_gm, cout_c, ovf_c, zero_c;
   logic [RW-1:0]    res_d, res_out;

   assign p2  = s1_use.p[WIDTH-1:0];
   assign g2  = s1_use.g[WIDTH-1:0];
   assign pm2 = s1_use.pm[NG-1:0];
   assign gm2 = s1_use.gm[NG-1:0];

   clu_nbits #(.N(NG)) u_tree (
      .p    (pm2),
      .g    (gm2),
      .cin  (s1_use.c0),
      .cout (gc),
      .pm   (tree_pm),
      .gm   (tree_gm)
   );

   for (genvar gi = 0; gi < NG; gi++) begin : g_grp2
      localparam int unsigned Base = gi * Grp;
      localparam int unsigned Len  = (Base + Grp > WIDTH) ? WIDTH - Base : Grp;
      clu_nbits #(.N(Len)) u_clu (
         .p    (p2[Base +: Len]),
         .g    (g2[Base +: Len]),
         .cin  (gc[gi]),
         .cout (c2[Base +: Len]),
         .pm   (unused_pm2[gi]),
         .gm   (unused_gm2[gi])
      );
   end

   assign sum_c  = p2 ^ c2;
   assign cout_c = tree_gm | (tree_pm & s1_use.c0);
   // Same-sign operands whose sum flips sign; equals c[WIDTH-1] ^ cout.
   assign ovf_c  = (s1_use.a_msb ~^ s1_use.bx_msb) & (s1_use.a_msb ^ sum_c[WIDTH-1]);
   assign zero_c = ~|sum_c;
   assign res_d  = {sum_c, cout_c, ovf_c, zero_c};

   // ---------------- pipeline control ----------------
   logic [STAGES:0]   rdy;
   logic [STAGES-1:0] v_q, v_in;

   // Ready ripples back from the output; a stage frees up as its occupant leaves.
   always_comb begin
      rdy         = '0;
      rdy[STAGES] = out_ready;
      for (int k = int'(STAGES) - 1; k >= 0; k--) rdy[k] = ~v_q[k] | rdy[k+1];
   end

   // Valid entering each stage.
   always_comb begin
      v_in    = '0;
      v_in[0] = in_valid;
      for (int k = 1; k < int'(STAGES); k++) v_in[k] = v_q[k-1];
   end

   // Stage valid bits advance whenever the stage may load.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         v_q <= '0;
      end else begin
         for (int k = 0; k < int'(STAGES); k++) begin
            if (rdy[k]) v_q[k] <= v_in[k];
         end
      end
   end

   assign in_ready  = rdy[0];
   assign out_valid = v_q[STAGES-1];

   // ---------------- pipeline data ----------------
   if (STAGES == 1) begin : g_comb_s1
      assign s1_use = s1_in;
   end else begin : g_reg_s1
      stage1_t s1_q;
      // Capture p/g payload only on an accepted beat.
      always_ff @(posedge clk or posedge rst) begin
         if (rst)                      s1_q <= '0;
         else if (rdy[0] && in_valid)  s1_q <= s1_in;
      end
      assign s1_use = s1_q;
   end

   logic [RW-1:0] res_q;
   // Result register loads only when a valid beat moves into it.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)                                 res_q <= '0;
      else if (rdy[ResStage] && v_in[ResStage]) res_q <= res_d;
   end

   if (STAGES >= 3) begin : g_out_reg
      logic [RW-1:0] out_q;
      // Extra output slice, same load rule as the stage before it.
      always_ff @(posedge clk or posedge rst) begin
         if (rst)                  out_q <= '0;
         else if (rdy[2] && v_q[1]) out_q <= res_q;
      end
      assign res_out = out_q;
   end else begin : g_no_out_reg
      assign res_out = res_q;
   end

   assign sum  = res_out[RW-1:3];
   assign cout = res_out[2];
   assign ovf  = res_out[1];
   assign zero = res_out[0];

   logic unused_s1;
   assign unused_s1 = ^s1_use;

endmodule
